// File: rtl/adder_tree_frame_ctrl_if.sv
// Frame-controller bundle: input word stream, tree vector/sum pair, result stream.
// Latency: none (signal container only).
// Backpressure: i_s_valid/o_s_ready on input, o_m_valid/i_m_ready on output.
interface adder_tree_frame_ctrl_if #(
  parameter int DATA_W   = 3,
  parameter int DATA_N   = 9,
  parameter int O_DATA_W = DATA_W + $clog2(DATA_N)
);
  logic                     i_s_valid;
  logic                     o_s_ready;
  logic [DATA_W-1:0]        i_s_data;
  logic [DATA_N*DATA_W-1:0] o_tree_data;
  logic [O_DATA_W-1:0]      i_tree_sum;
  logic                     o_m_valid;
  logic                     i_m_ready;
  logic [O_DATA_W-1:0]      o_m_data;

  // Controller side of the bundle
  modport slave (
    input  i_s_valid, i_s_data, i_tree_sum, i_m_ready,
    output o_s_ready, o_tree_data, o_m_valid, o_m_data
  );

  // Environment side: word source, adder tree and result sink
  modport master (
    output i_s_valid, i_s_data, i_tree_sum, i_m_ready,
    input  o_s_ready, o_tree_data, o_m_valid, o_m_data
  );
endinterface

// File: rtl/adder_tree_frame_ctrl.sv
// Gathers DATA_N words into a frame for the adder tree and returns its sum; optional ADDER_TREE_FRAME_SELFCHECK_EN adds a sticky sum check.
// Latency: o_m_valid rises TREE_LAT+1 cycles after the last word of a frame is accepted.
// Backpressure: o_s_ready only in FILL; the result is held in HOLD until i_m_ready, then FILL resumes next cycle.
module adder_tree_frame_ctrl #(
  parameter int DATA_W   = 3,
  parameter int DATA_N   = 9,
  parameter int TREE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adder_tree_frame_ctrl_if.slave   bus,
  output logic                     o_busy,
  output logic                     o_err
);
  localparam int O_DATA_W = DATA_W + $clog2(DATA_N);
  localparam int IDX_W    = $clog2(DATA_N);
  localparam int CNT_W    = $clog2(TREE_LAT + 1);

  typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [CNT_W-1:0]               cnt;
  logic [DATA_N-1:0][DATA_W-1:0]  frame;
  logic                           m_valid;
  logic [O_DATA_W-1:0]            m_data;

`ifdef ADDER_TREE_FRAME_SELFCHECK_EN
  logic [O_DATA_W-1:0]            acc;
  logic                           err;
`endif

  // Frame sequencing: fill slots, wait out the tree pipeline, hold the result until taken.
  // The counter is loaded at the last accept and the sum is taken once it has run down to
  // zero, which lines the capture up with the tree's output after TREE_LAT register stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      idx     <= '0;
      cnt     <= '0;
      frame   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
`ifdef ADDER_TREE_FRAME_SELFCHECK_EN
      acc     <= '0;
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (bus.i_s_valid) begin
            frame[idx] <= bus.i_s_data;
`ifdef ADDER_TREE_FRAME_SELFCHECK_EN
            // Slot 0 restarts the reference so no earlier frame leaks in
            acc <= ((idx == '0) ? '0 : acc) + O_DATA_W'(bus.i_s_data);
`endif
            if (idx == IDX_W'(DATA_N - 1)) begin
              idx   <= '0;
              cnt   <= CNT_W'(TREE_LAT);
              state <= WAIT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            m_data  <= bus.i_tree_sum;
            m_valid <= 1'b1;
            state   <= HOLD;
`ifdef ADDER_TREE_FRAME_SELFCHECK_EN
            if (bus.i_tree_sum != acc) err <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.i_m_ready) begin
            m_valid <= 1'b0;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.o_s_ready   = (state == FILL);
  assign bus.o_tree_data = frame;
  assign bus.o_m_valid   = m_valid;
  assign bus.o_m_data    = m_data;
  assign o_busy          = (state != FILL);

`ifdef ADDER_TREE_FRAME_SELFCHECK_EN
  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_adder_tree_frame_ctrl.sv
// Bench for adder_tree_frame_ctrl: directed and randomized frames against a sum-of-words model.
// Latency: checks TREE_LAT+1 cycles from last accept to o_m_valid.
// Backpressure: exercises input gaps, held-off results and reset during the tree wait.
module tb_adder_tree_frame_ctrl;
  localparam int DATA_W   = 3;
  localparam int DATA_N   = 9;
  localparam int TREE_LAT = 3;
  localparam int O_DATA_W = DATA_W + $clog2(DATA_N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic o_busy;
  logic o_err;

  adder_tree_frame_ctrl_if #(.DATA_W(DATA_W), .DATA_N(DATA_N), .O_DATA_W(O_DATA_W)) bus ();

  adder_tree_frame_ctrl #(.DATA_W(DATA_W), .DATA_N(DATA_N), .TREE_LAT(TREE_LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .o_busy (o_busy),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  // Adder tree stand-in: TREE_LAT register stages, optional +1 corruption on the output
  logic [O_DATA_W-1:0] pipe [TREE_LAT];
  bit corrupt = 1'b0;

  function automatic int tree_ref(input logic [DATA_N*DATA_W-1:0] v);
    int s = 0;
    for (int i = 0; i < DATA_N; i++) s += int'(v[i*DATA_W +: DATA_W]);
    return s;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= O_DATA_W'(tree_ref(bus.o_tree_data));
    for (int k = 1; k < TREE_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.i_tree_sum = pipe[TREE_LAT-1] + O_DATA_W'(corrupt);

  int vectors = 0;
  int miscompares = 0;
  int words [DATA_N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    foreach (words[i]) s += words[i];
    return s;
  endfunction

  task automatic fill_words(input int mode, input int val);
    foreach (words[i]) words[i] = (mode == 0) ? val : int'($urandom_range(0, 7));
  endtask

  // Present one word and wait (bounded) until it is accepted
  task automatic push(input int w, input bit gaps);
    int t = 0;
    if (gaps) begin
      bus.i_s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = DATA_W'(w);
    forever begin
      @(negedge clk);
      if (bus.o_s_ready) break;
      t++;
      if (t > 50) begin
        check("push_ready_timeout", {31'd0, bus.o_s_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.i_s_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < DATA_N; i++) push(words[i], gaps);
  endtask

  // Measure latency from the last accept, check hold stability, then hand the result off
  task automatic get_result(input string tag, input int exp, input int hold);
    int lat = 0;
    bit wait_ok = 1'b1;
    bit stable = 1'b1;
    while (!bus.o_m_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.o_m_valid && (bus.o_s_ready !== 1'b0 || o_busy !== 1'b1)) wait_ok = 1'b0;
    end
    check({tag, "_latency"}, lat, TREE_LAT + 1);
    check({tag, "_wait_ready_low"}, {31'd0, wait_ok}, 32'd1);
    check({tag, "_sum"}, {25'd0, bus.o_m_data}, exp);
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (bus.o_m_valid !== 1'b1 || int'(bus.o_m_data) != exp || bus.o_s_ready !== 1'b0)
        stable = 1'b0;
    end
    check({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
    bus.i_m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_m_ready = 1'b0;
    check({tag, "_valid_cleared"}, {31'd0, bus.o_m_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.o_s_ready}, 32'd1);
  endtask

  initial begin
    bit pulse;
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    bus.i_m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {31'd0, bus.o_m_valid}, 32'd0);
    check("rst_m_data", {25'd0, bus.o_m_data}, 32'd0);
    check("rst_tree_data", {5'd0, bus.o_tree_data}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", {31'd0, bus.o_s_ready}, 32'd1);

    // Directed frame 0..7,1 back-to-back
    for (int i = 0; i < 8; i++) words[i] = i;
    words[8] = 1;
    send_frame(1'b0);
    get_result("seq", model_sum(), 0);

    // All-ones words: largest possible sum
    fill_words(0, 7);
    send_frame(1'b0);
    get_result("max", model_sum(), 2);

    // Random words with input gaps, result held off 5 cycles
    fill_words(1, 0);
    send_frame(1'b1);
    get_result("gap_hold", model_sum(), 5);

    // Follow-up frame of 1s overwrites every slot
    fill_words(0, 1);
    send_frame(1'b0);
    get_result("ones", model_sum(), 0);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      fill_words(1, 0);
      send_frame(f[0]);
      get_result("rand", model_sum(), int'($urandom_range(0, 4)));
    end

    // Reset during the tree wait discards the frame without a result pulse
    fill_words(0, 7);
    send_frame(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_ready", {31'd0, bus.o_s_ready}, 32'd1);
    check("midrst_tree_data", {5'd0, bus.o_tree_data}, 32'd0);
    pulse = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.o_m_valid !== 1'b0) pulse = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.o_m_valid !== 1'b0) pulse = 1'b1;
    end
    check("midrst_no_pulse", {31'd0, pulse}, 32'd0);
    fill_words(0, 2);
    send_frame(1'b0);
    get_result("after_rst", model_sum(), 1);

`ifdef ADDER_TREE_FRAME_SELFCHECK_EN
    // Tree disagreement latches o_err until reset
    check("sc_err_clean", {31'd0, o_err}, 32'd0);
    corrupt = 1'b1;
    fill_words(1, 0);
    send_frame(1'b0);
    get_result("sc_bad", model_sum() + 1, 1);
    corrupt = 1'b0;
    check("sc_err_set", {31'd0, o_err}, 32'd1);
    fill_words(1, 0);
    send_frame(1'b1);
    get_result("sc_good", model_sum(), 0);
    check("sc_err_sticky", {31'd0, o_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("sc_err_reset", {31'd0, o_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`else
    check("err_tied_low", {31'd0, o_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
